// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multi-cycle control sequencer. Each instruction goes through FETCH, DECODE
//   and then EXEC / SPDEC / MEM / WB as its class needs. The FSM handshakes with
//   a shared memory port (mem_req held until mem_ready) and drives the datapath
//   mux selects. It also handles stack ops (PUSH/POP/CALL/RET), HALT with
//   resume, and illegal-opcode flagging, and keeps a wrapping count of retired
//   instructions.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   opcode              IR opcode field, sampled in DECODE
//   branch_taken        condition result for the current branch_op
//   mem_ready           memory completes the current request this cycle
//   resume              leave HALTED
//   mem_req/mem_we      memory request / write strobe
//   addr_sel/wdata_sel  memory address mux (PC/ALU/SP) / write data mux (rt/PC)
//   ir_load             latch IR
//   pc_write/pc_src     PC update enable / source (PC+1, target, mem data)
//   branch_op           branch condition select
//   alu_op/alu_src      ALU function / operand B select
//   reg_write/reg_dst   register write enable / destination (rd or rt)
//   mem_to_reg          write-back source is memory data
//   sp_op               stack pointer hold / decrement / increment
//   halted, illegal     in HALTED / one-cycle undefined-opcode pulse
//   retired             completed-instruction count
module multicycle_control_fsm #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch_taken,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                mem_req,
  output logic                mem_we,
  output logic [1:0]          addr_sel,
  output logic                wdata_sel,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [2:0]          branch_op,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic [1:0]          sp_op,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);
  localparam logic [5:0] OP_R    = 6'h00, OP_ADDI = 6'h01, OP_SRAI = 6'h09,
                         OP_BR   = 6'h0A, OP_BMI  = 6'h0B, OP_BPL  = 6'h0C,
                         OP_BZ   = 6'h0D, OP_LD   = 6'h0E, OP_ST   = 6'h0F,
                         OP_LDSP = 6'h10, OP_STSP = 6'h11, OP_MOVE = 6'h12,
                         OP_PUSH = 6'h13, OP_POP  = 6'h14, OP_CALL = 6'h15,
                         OP_HALT = 6'h16, OP_NOP  = 6'h17, OP_RET  = 6'h18;

  localparam logic [ALUOP_W-1:0] ALU_R    = '0;
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_PASS = '1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_SPDEC, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t     state, state_nx;
  logic [5:0] op_q;
  logic [5:0] d6;
  logic       d_legal;
  // run stays low for one cycle after reset so every output reads 0 until
  // the first edge with rst deasserted.
  logic       run;
  logic       retire;
  logic       q_alui, q_br, q_ldst, q_load, q_store;

  assign d6      = opcode[5:0];
  assign d_legal = ((opcode >> 6) == '0) && (d6 <= OP_RET);

  // Only legal opcodes are ever latched, so these classify the current one.
  assign q_alui  = (op_q >= OP_ADDI) && (op_q <= OP_SRAI);
  assign q_br    = (op_q >= OP_BR) && (op_q <= OP_BZ);
  assign q_ldst  = (op_q >= OP_LD) && (op_q <= OP_STSP);
  assign q_load  = (op_q == OP_LD) || (op_q == OP_LDSP);
  // Everything that finishes on a memory write.
  assign q_store = (op_q == OP_ST) || (op_q == OP_STSP) ||
                   (op_q == OP_PUSH) || (op_q == OP_CALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      run     <= 1'b0;
      op_q    <= '0;
      retired <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nx;
      if (state == S_DECODE) op_q <= d6;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 2'd0;
    wdata_sel  = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    branch_op  = 3'd0;
    alu_op     = ALU_R;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    sp_op      = 2'd0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (run) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            state_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!d_legal) begin
            illegal  = 1'b1;
            state_nx = S_FETCH;
          end else begin
            case (d6)
              OP_HALT:          state_nx = S_HALTED;
              OP_NOP:           begin state_nx = S_FETCH; retire = 1'b1; end
              OP_PUSH, OP_CALL: state_nx = S_SPDEC;
              OP_POP, OP_RET:   state_nx = S_MEM;
              default:          state_nx = S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          if (q_br) begin
            // ALU forms the branch target while the datapath evaluates the condition.
            alu_op   = ALU_ADD;
            alu_src  = 1'b1;
            pc_write = branch_taken;
            pc_src   = 2'd1;
            state_nx = S_FETCH;
            retire   = 1'b1;
            case (op_q)
              OP_BR:   branch_op = 3'd1;
              OP_BPL:  branch_op = 3'd2;
              OP_BMI:  branch_op = 3'd3;
              default: branch_op = 3'd4;
            endcase
          end else if (q_ldst) begin
            alu_op   = ALU_ADD;
            alu_src  = 1'b1;
            state_nx = S_MEM;
          end else begin
            // ALU immediates map 1:1 onto the ALU function codes.
            if (q_alui) begin
              alu_op  = ALUOP_W'(op_q);
              alu_src = 1'b1;
            end else if (op_q == OP_MOVE) begin
              alu_op = ALU_PASS;
            end
            state_nx = S_WB;
          end
        end
        S_SPDEC: begin
          sp_op    = 2'd1;
          state_nx = S_MEM;
        end
        S_MEM: begin
          mem_req   = 1'b1;
          addr_sel  = q_ldst ? 2'd1 : 2'd2;
          mem_we    = q_store;
          wdata_sel = (op_q == OP_CALL);
          pc_src    = (op_q == OP_CALL) ? 2'd1 : 2'd0;
          if (mem_ready) begin
            if (q_store) begin
              pc_write = (op_q == OP_CALL);
              state_nx = S_FETCH;
              retire   = 1'b1;
            end else begin
              state_nx = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write  = (op_q != OP_RET);
          mem_to_reg = q_load || (op_q == OP_POP);
          reg_dst    = (op_q == OP_R);
          if ((op_q == OP_POP) || (op_q == OP_RET)) sp_op = 2'd2;
          if (op_q == OP_RET) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
          state_nx = S_FETCH;
          retire   = 1'b1;
        end
        S_HALTED: begin
          halted = 1'b1;
          if (resume) begin
            state_nx = S_FETCH;
            retire   = 1'b1;
          end
        end
        default: state_nx = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. Each instruction is expanded into the
// per-cycle control vectors its class should produce (with chosen memory
// stalls, branch outcome and halt length), then replayed cycle by cycle.
module tb_multicycle_control_fsm;
  logic        clk = 1'b0;
  logic        rst, branch_taken, mem_ready, resume;
  logic [5:0]  opcode;
  logic        mem_req, mem_we, wdata_sel, ir_load, pc_write, alu_src;
  logic        reg_write, reg_dst, mem_to_reg, halted, illegal;
  logic [1:0]  addr_sel, pc_src, sp_op;
  logic [2:0]  branch_op;
  logic [3:0]  alu_op;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .resume(resume), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .wdata_sel(wdata_sel), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src), .branch_op(branch_op), .alu_op(alu_op),
    .alu_src(alu_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .sp_op(sp_op), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  typedef struct packed {
    logic       mem_req, mem_we;
    logic [1:0] addr_sel;
    logic       wdata_sel, ir_load, pc_write;
    logic [1:0] pc_src;
    logic [2:0] branch_op;
    logic [3:0] alu_op;
    logic       alu_src, reg_write, reg_dst, mem_to_reg;
    logic [1:0] sp_op;
    logic       halted, illegal;
  } ctl_t;

  typedef struct {
    logic mr, bt, rs;
    ctl_t c;
  } step_t;

  ctl_t        obs;
  step_t       tr[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 0;

  assign obs = {mem_req, mem_we, addr_sel, wdata_sel, ir_load, pc_write, pc_src,
                branch_op, alu_op, alu_src, reg_write, reg_dst, mem_to_reg,
                sp_op, halted, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic mr, input logic bt, input logic rs, input ctl_t c);
    step_t s;
    s.mr = mr; s.bt = bt; s.rs = rs; s.c = c;
    tr.push_back(s);
  endtask

  // Memory phase: mst stalled cycles, then the completing cycle. pcw marks
  // the PC update that comes with completion (CALL).
  task automatic mem_phase(input ctl_t c, input int mst, input logic pcw);
    ctl_t f;
    for (int i = 0; i < mst; i++) add(1'b0, rb(), rb(), c);
    f = c;
    f.pc_write = pcw;
    add(1'b1, rb(), rb(), f);
  endtask

  // Expected trace of one instruction; dret is what it adds to retired.
  task automatic build(input logic [5:0] op, input int fst, input int mst,
                       input logic bt, input int hlt, output int dret);
    ctl_t c, m;
    tr.delete();
    c = '0; c.mem_req = 1'b1;
    for (int i = 0; i < fst; i++) add(1'b0, rb(), rb(), c);
    c.ir_load = 1'b1; c.pc_write = 1'b1;
    add(1'b1, rb(), rb(), c);
    c = '0; c.illegal = (op > 6'h18);
    add(rb(), rb(), rb(), c);
    dret = 1;
    m = '0; m.mem_req = 1'b1;
    if (op > 6'h18) begin
      dret = 0;
    end else begin
      case (op)
        6'h17: ;
        6'h16: begin
          c = '0; c.halted = 1'b1;
          for (int i = 0; i < hlt; i++) add(rb(), rb(), 1'b0, c);
          add(rb(), rb(), 1'b1, c);
        end
        6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
          c = '0;
          c.branch_op = (op == 6'h0A) ? 3'd1 : (op == 6'h0B) ? 3'd3 :
                        (op == 6'h0C) ? 3'd2 : 3'd4;
          c.alu_op = 4'd1; c.alu_src = 1'b1; c.pc_src = 2'd1; c.pc_write = bt;
          add(rb(), bt, rb(), c);
        end
        6'h0E, 6'h10: begin
          c = '0; c.alu_op = 4'd1; c.alu_src = 1'b1;
          add(rb(), rb(), rb(), c);
          m.addr_sel = 2'd1;
          mem_phase(m, mst, 1'b0);
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
          add(rb(), rb(), rb(), c);
        end
        6'h0F, 6'h11: begin
          c = '0; c.alu_op = 4'd1; c.alu_src = 1'b1;
          add(rb(), rb(), rb(), c);
          m.addr_sel = 2'd1; m.mem_we = 1'b1;
          mem_phase(m, mst, 1'b0);
        end
        6'h13, 6'h15: begin
          c = '0; c.sp_op = 2'd1;
          add(rb(), rb(), rb(), c);
          m.addr_sel = 2'd2; m.mem_we = 1'b1;
          if (op == 6'h15) begin m.wdata_sel = 1'b1; m.pc_src = 2'd1; end
          mem_phase(m, mst, op == 6'h15);
        end
        6'h14, 6'h18: begin
          m.addr_sel = 2'd2;
          mem_phase(m, mst, 1'b0);
          c = '0; c.sp_op = 2'd2;
          if (op == 6'h14) begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
          else begin c.pc_write = 1'b1; c.pc_src = 2'd2; end
          add(rb(), rb(), rb(), c);
        end
        default: begin
          // R-type, ALU immediates, MOVE
          c = '0;
          c.alu_op  = (op == 6'h00) ? 4'd0 : (op == 6'h12) ? 4'hF : op[3:0];
          c.alu_src = (op != 6'h00) && (op != 6'h12);
          add(rb(), rb(), rb(), c);
          c = '0; c.reg_write = 1'b1; c.reg_dst = (op == 6'h00);
          add(rb(), rb(), rb(), c);
        end
      endcase
    end
  endtask

  task automatic run(input logic [5:0] op, input int n);
    for (int i = 0; i < tr.size() && i < n; i++) begin
      @(posedge clk); #1;
      opcode = op;
      mem_ready = tr[i].mr; branch_taken = tr[i].bt; resume = tr[i].rs;
      @(negedge clk);
      chk($sformatf("ctl op%02h s%0d", op, i), 32'(obs), 32'(tr[i].c));
      chk($sformatf("ret op%02h s%0d", op, i), retired, exp_ret);
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input int fst, input int mst,
                          input logic bt, input int hlt);
    int dret;
    build(op, fst, mst, bt, hlt, dret);
    run(op, 1000);
    exp_ret = exp_ret + 32'(dret);
  endtask

  initial begin
    int dret;
    logic [5:0] op;
    rst = 1'b1; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b1; resume = 1'b1;
    @(negedge clk);
    chk("rst_ctl", 32'(obs), 32'd0);
    chk("rst_ret", retired, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("release_ctl", 32'(obs), 32'd0);

    do_instr(6'h01, 0, 0, 1'b0, 0);   // ADDI
    do_instr(6'h0E, 0, 3, 1'b0, 0);   // LD, 3 stall cycles in MEM
    do_instr(6'h15, 1, 1, 1'b0, 0);   // CALL
    do_instr(6'h18, 0, 2, 1'b0, 0);   // RET
    do_instr(6'h0D, 0, 0, 1'b0, 0);   // BZ not taken
    do_instr(6'h0D, 0, 0, 1'b1, 0);   // BZ taken
    do_instr(6'h16, 0, 0, 1'b0, 10);  // HALT, 10 cycles before resume
    do_instr(6'h3F, 0, 0, 1'b0, 0);   // illegal
    do_instr(6'h00, 2, 0, 1'b0, 0);   // R-type
    do_instr(6'h12, 0, 0, 1'b0, 0);   // MOVE

    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(25, 63))
                                       : 6'($urandom_range(0, 24));
      do_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb(),
               $urandom_range(0, 4));
    end

    // Reset during a MEM stall: reset wins over mem_ready and clears everything.
    build(6'h0F, 0, 6, 1'b0, 0, dret);
    run(6'h0F, 5);
    @(posedge clk); #1 rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    chk("midrst_ctl", 32'(obs), 32'd0);
    chk("midrst_ret", retired, exp_ret);
    do_instr(6'h17, 0, 0, 1'b0, 0);   // NOP after restart
    do_instr(6'h13, 0, 1, 1'b0, 0);   // PUSH
    do_instr(6'h14, 0, 1, 1'b0, 0);   // POP
    @(posedge clk); #1;
    @(negedge clk);
    chk("final_ret", retired, exp_ret);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
